// File: rtl/seg_scan_controller_pkg.sv
// Shared seven-segment definitions: segment bit order, blank pattern and the
// golden hex decode table used as the reference for the decoder.
package seg_scan_controller_pkg;

  // Segment vector layout is {a,b,c,d,e,f,g}; a is the MSB.
  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [SEG_W-1:0] seg_golden(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Load port of the scan controller: the producing datapath offers a packed hex
// value, the controller accepts it into its pending buffer.
interface seg_scan_controller_if #(
  parameter int N_DIGITS = 4
);
  // Handshake: a transfer happens on a rising clk edge where load_valid and
  // load_ready are both high. load_ready depends only on controller state, never
  // on load_valid; the master holds load_data stable while load_valid is high.
  logic                    load_valid;
  logic [4*N_DIGITS-1:0]   load_data;
  logic                    load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/hex_seg_decoder.sv
// Combinational hex digit to seven-segment pattern, {a,b,c,d,e,f,g}, active-high.
module hex_seg_decoder
  import seg_scan_controller_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scanner with a double-buffered value that only
// changes on frame boundaries, plus optional leading-zero blanking.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_controller_if.slave load,
  input  logic [N_DIGITS-1:0] dp_mask,
  input  logic                blank_en,
  output logic [N_DIGITS-1:0] an,
  output logic [SEG_W-1:0]    seg,
  output logic                dp,
  output logic                frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;

  logic [PW-1:0] presc_cnt;
  logic [IW-1:0] idx;
  logic [DW-1:0] active;
  logic [DW-1:0] pending;
  logic          pending_full;

  logic          tick;
  logic          wrap;
  logic          load_fire;
  logic [3:0]    cur_digit;
  logic [SEG_W-1:0] cur_seg;
  logic [N_DIGITS-1:0] tail_zero;
  logic          blanked;

  assign tick       = (presc_cnt == PW'(PRESCALE - 1));
  assign wrap       = tick && (idx == IW'(N_DIGITS - 1));
  assign load.load_ready = ~pending_full;
  assign load_fire  = load.load_valid && ~pending_full;

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      idx       <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      if (tick) begin
        idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      end
    end
  end

  // Pending/active double buffer. A load and a transfer can never coincide:
  // loads need an empty pending buffer, transfers need a full one, so a value
  // accepted on a wrap edge waits for the following wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (load_fire) begin
      pending      <= load.load_data;
      pending_full <= 1'b1;
    end else if (wrap && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end
  end

  // tail_zero[i] is set when digits i..N_DIGITS-1 of the active value are all zero.
  always_comb begin
    logic zero_acc;
    zero_acc  = 1'b1;
    tail_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (active[4*i +: 4] == 4'h0);
      tail_zero[i] = zero_acc;
    end
  end

  assign cur_digit = active[{idx, 2'b00} +: 4];
  assign blanked   = blank_en && (idx != '0) && tail_zero[idx];

  hex_seg_decoder u_decoder (
    .hex (cur_digit),
    .seg (cur_seg)
  );

  // Registered pin drivers; they reflect the digit selected before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= ~(N_DIGITS'(1) << idx);
      seg        <= blanked ? SEG_BLANK : cur_seg;
      dp         <= dp_mask[idx];
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with N_DIGITS=4, PRESCALE=4: reset,
// load/scan, blanking, backpressure, load-on-wrap, decoder sweep, mid-frame reset.
module tb_seg_scan_controller;
  import seg_scan_controller_pkg::*;

  localparam int N_DIGITS = 4;
  localparam int PRESCALE = 4;

  logic                clk;
  logic                rst;
  logic [N_DIGITS-1:0] dp_mask;
  logic                blank_en;
  logic [N_DIGITS-1:0] an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_done;

  int checks   = 0;
  int failures = 0;

  seg_scan_controller_if #(.N_DIGITS(N_DIGITS)) ld_if ();

  seg_scan_controller #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (ld_if.slave),
    .dp_mask    (dp_mask),
    .blank_en   (blank_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_an"},    32'(an),         32'hF);
    chk({tag, "_seg"},   32'(seg),        32'h0);
    chk({tag, "_dp"},    32'(dp),         32'h0);
    chk({tag, "_fd"},    32'(frame_done), 32'h0);
    chk({tag, "_ready"}, 32'(ld_if.load_ready), 32'h1);
  endtask

  // Steps frame positions first..last (0..15) and checks the pins at each.
  // segs packs the expected pattern per digit: [27:21]=digit3 .. [6:0]=digit0.
  task automatic run_span(input string tag, input logic [27:0] segs,
                          input logic [3:0] dpm, input int first, input int last);
    for (int e = first; e <= last; e++) begin
      int         d;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      d       = e / PRESCALE;
      exp_an  = ~(4'b0001 << d);
      exp_seg = segs[7*d +: 7];
      step();
      chk($sformatf("%s_an_p%0d", tag, e),  32'(an),         32'(exp_an));
      chk($sformatf("%s_seg_p%0d", tag, e), 32'(seg),        32'(exp_seg));
      chk($sformatf("%s_dp_p%0d", tag, e),  32'(dp),         32'(dpm[d]));
      chk($sformatf("%s_fd_p%0d", tag, e),  32'(frame_done), 32'(e == 15));
    end
  endtask

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] SB = 7'b0000000;

  // Directed stimulus
  initial begin
    rst               = 1'b1;
    ld_if.load_valid  = 1'b1;
    ld_if.load_data   = 16'hBEEF;
    dp_mask           = 4'b0000;
    blank_en          = 1'b0;

    // Reset held 3 cycles with a load offered: nothing may be captured.
    repeat (3) step();
    chk_reset_values("reset");

    // Frame 0: load 1234 on the first edge, display still shows zeros.
    rst             = 1'b0;
    ld_if.load_data = 16'h1234;
    run_span("f0", {4{S0}}, 4'b0000, 0, 0);
    chk("f0_ready_after_load", 32'(ld_if.load_ready), 32'h0);
    ld_if.load_valid = 1'b0;
    run_span("f0", {4{S0}}, 4'b0000, 1, 14);
    chk("f0_ready_before_wrap", 32'(ld_if.load_ready), 32'h0);
    run_span("f0", {4{S0}}, 4'b0000, 15, 15);
    chk("f0_ready_after_wrap", 32'(ld_if.load_ready), 32'h1);

    // Frame 1: 1234 displayed; 0050 loaded meanwhile.
    dp_mask          = 4'b1010;
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h0050;
    run_span("f1", {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b1010, 0, 0);
    ld_if.load_valid = 1'b0;
    run_span("f1", {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b1010, 1, 15);
    chk("f1_ready_after_wrap", 32'(ld_if.load_ready), 32'h1);

    // Frame 2: 0050 with blanking; blanked digit 2 still shows its dp.
    blank_en = 1'b1;
    dp_mask  = 4'b0100;
    run_span("f2", {SB, SB, 7'b1011011, S0}, 4'b0100, 0, 15);

    // Frame 3: blanking off; load 00AA then offer FFFF under backpressure.
    blank_en         = 1'b0;
    dp_mask          = 4'b0000;
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h00AA;
    run_span("f3", {S0, S0, 7'b1011011, S0}, 4'b0000, 0, 0);
    chk("f3_ready_after_load", 32'(ld_if.load_ready), 32'h0);
    ld_if.load_data = 16'hFFFF;
    run_span("f3", {S0, S0, 7'b1011011, S0}, 4'b0000, 1, 15);
    chk("f3_ready_after_wrap", 32'(ld_if.load_ready), 32'h1);

    // Frame 4: 00AA shown (blanked), FFFF now accepted.
    blank_en = 1'b1;
    run_span("f4", {SB, SB, 7'b1110111, 7'b1110111}, 4'b0000, 0, 0);
    chk("f4_ready_after_load", 32'(ld_if.load_ready), 32'h0);
    ld_if.load_valid = 1'b0;
    run_span("f4", {SB, SB, 7'b1110111, 7'b1110111}, 4'b0000, 1, 15);

    // Frame 5: FFFF shown; 0007 offered exactly on the wrap edge.
    run_span("f5", {4{7'b1000111}}, 4'b0000, 0, 14);
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h0007;
    run_span("f5", {4{7'b1000111}}, 4'b0000, 15, 15);
    chk("f5_ready_load_on_wrap", 32'(ld_if.load_ready), 32'h0);
    ld_if.load_valid = 1'b0;

    // Frame 6: 0007 must not appear yet; frame 7 shows it.
    run_span("f6", {4{7'b1000111}}, 4'b0000, 0, 15);
    chk("f6_ready_after_wrap", 32'(ld_if.load_ready), 32'h1);
    run_span("f7", {SB, SB, SB, 7'b1110000}, 4'b0000, 0, 15);

    // Decoder sweep on digit 0 against the golden table.
    blank_en = 1'b0;
    for (int v = 0; v <= 16; v++) begin
      ld_if.load_valid = (v < 16);
      ld_if.load_data  = 16'(v);
      step();
      if (v > 0) begin
        chk($sformatf("sweep_an_%0h", v - 1),  32'(an),  32'hE);
        chk($sformatf("sweep_seg_%0h", v - 1), 32'(seg), 32'(SEG_TABLE[v - 1]));
      end
      ld_if.load_valid = 1'b0;
      if (v < 16) repeat (15) step();
    end

    // Mid-frame reset while idx=2 with a value pending.
    dp_mask          = 4'b1111;
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h9999;
    step();
    chk("mid_ready_after_load", 32'(ld_if.load_ready), 32'h0);
    ld_if.load_valid = 1'b0;
    repeat (7) step();
    chk("mid_an_idx2", 32'(an), 32'hB);
    rst = 1'b1;
    step();
    chk_reset_values("mid_reset");
    rst = 1'b0;
    run_span("post_rst_a", {4{S0}}, 4'b1111, 0, 15);
    run_span("post_rst_b", {4{S0}}, 4'b1111, 0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
